// File: rtl/sram_access_ctrl.sv
// Burst initiator for one single-port synchronous SRAM: valid/ready commands and write beats in, read beats out.
// Read beat valid 3 cycles after the command; a stalled read beat (rd_ready low) parks the SRAM with mem_cs low.
module sram_access_ctrl #(
  parameter int ADDR  = 8,
  parameter int DATA  = 8,
  parameter int DEPTH = 8,
  parameter int LENW  = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [ADDR-1:0] req_addr,
  input  logic [LENW-1:0] req_len,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [DATA-1:0] wr_data,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [DATA-1:0] rd_data,
  output logic            rd_last,
  output logic            done,
  output logic            err,
  output logic            mem_cs,
  output logic            mem_rd,
  output logic [ADDR-1:0] mem_addr,
  output logic [DATA-1:0] mem_wdata,
  input  logic [DATA-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_WAIT, RD_RESP, DONE} state_t;

  localparam logic [ADDR:0]   DEPTH_X   = (ADDR+1)'(DEPTH);
  localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(DEPTH - 1);

  state_t          state, state_d;
  logic [ADDR-1:0] cur_addr, cur_addr_d, next_addr;
  logic [LENW-1:0] beats_left, beats_d;
  logic            mem_cs_d, mem_rd_d;
  logic [ADDR-1:0] mem_addr_d;
  logic [DATA-1:0] mem_wdata_d, rd_data_d;
  logic            rd_valid_d, rd_last_d, done_d, err_d;
  logic            addr_bad;

  assign req_ready = (state == IDLE);
  assign wr_ready  = (state == WR);
  assign addr_bad  = ({1'b0, req_addr} >= DEPTH_X);
  // Wrap at the real memory size, not at the address width.
  assign next_addr = (cur_addr == LAST_ADDR) ? '0 : cur_addr + 1'b1;

  always_comb begin
    state_d     = state;
    cur_addr_d  = cur_addr;
    beats_d     = beats_left;
    mem_cs_d    = 1'b0;
    mem_rd_d    = 1'b1;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    rd_valid_d  = rd_valid;
    rd_data_d   = rd_data;
    rd_last_d   = rd_last;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          cur_addr_d = req_addr;
          beats_d    = req_len;
          if (addr_bad) begin
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else if (req_write) begin
            state_d = WR;
          end else begin
            state_d    = RD_ISSUE;
            mem_cs_d   = 1'b1;
            mem_addr_d = req_addr;
          end
        end
      end
      WR: begin
        if (wr_valid) begin
          mem_cs_d    = 1'b1;
          mem_rd_d    = 1'b0;
          mem_addr_d  = cur_addr;
          mem_wdata_d = wr_data;
          cur_addr_d  = next_addr;
          beats_d     = beats_left - 1'b1;
          if (beats_left == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        rd_data_d  = mem_rdata;
        rd_valid_d = 1'b1;
        rd_last_d  = (beats_left == '0);
        state_d    = RD_RESP;
      end
      RD_RESP: begin
        // The next read is only issued once the pending beat is consumed.
        if (rd_ready) begin
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
          if (rd_last) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d    = RD_ISSUE;
            mem_cs_d   = 1'b1;
            mem_addr_d = next_addr;
            cur_addr_d = next_addr;
            beats_d    = beats_left - 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cur_addr   <= '0;
      beats_left <= '0;
      mem_cs     <= 1'b0;
      mem_rd     <= 1'b1;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      rd_last    <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_d;
      cur_addr   <= cur_addr_d;
      beats_left <= beats_d;
      mem_cs     <= mem_cs_d;
      mem_rd     <= mem_rd_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      rd_valid   <= rd_valid_d;
      rd_data    <= rd_data_d;
      rd_last    <= rd_last_d;
      done       <= done_d;
      err        <= err_d;
    end
  end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: behavioural SRAM, strobe/beat/done scoreboards, vector table plus corner sequences.
module tb_sram_access_ctrl;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       req_valid = 1'b0, req_write = 1'b0;
  logic [7:0] req_addr = '0;
  logic [1:0] req_len = '0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = '0;
  logic       rd_ready = 1'b1;
  logic       req_ready, wr_ready, rd_valid, rd_last, done, err;
  logic       mem_cs, mem_rd;
  logic [7:0] rd_data, mem_addr, mem_wdata;
  logic [7:0] mem_rdata = '0;

  always #5 clk = ~clk;

  sram_access_ctrl #(.ADDR(8), .DATA(8), .DEPTH(8), .LENW(2)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .err(err),
    .mem_cs(mem_cs), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  logic [7:0] sram [0:7];
  initial for (int i = 0; i < 8; i++) sram[i] = 8'hF0 + 8'(i);

  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_rd) mem_rdata <= sram[mem_addr[2:0]];
      else        sram[mem_addr[2:0]] = mem_wdata;
    end
  end

  typedef struct packed { logic [7:0] addr; logic [7:0] data; } strobe_t;
  typedef struct packed { logic [7:0] data; logic last; } beat_t;
  typedef struct {
    logic            w;
    logic [7:0]      a;
    logic [1:0]      l;
    logic [3:0][7:0] d;
    logic            e;
  } vec_t;

  strobe_t    ws_q[$];
  logic [7:0] rs_q[$];
  beat_t      rb_q[$];
  logic       done_q[$];
  int errors = 0;
  int checks = 0;
  strobe_t mon_s;
  beat_t   mon_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      if (mem_cs && mem_rd) begin
        check("rd_strobe_expected", 32'(rs_q.size() > 0), 1);
        if (rs_q.size() > 0) check("rd_strobe_addr", 32'(mem_addr), 32'(rs_q.pop_front()));
      end
      if (mem_cs && !mem_rd) begin
        check("wr_strobe_expected", 32'(ws_q.size() > 0), 1);
        if (ws_q.size() > 0) begin
          mon_s = ws_q.pop_front();
          check("wr_strobe_addr", 32'(mem_addr), 32'(mon_s.addr));
          check("wr_strobe_data", 32'(mem_wdata), 32'(mon_s.data));
        end
      end
      if (rd_valid && rd_ready) begin
        check("rd_beat_expected", 32'(rb_q.size() > 0), 1);
        if (rb_q.size() > 0) begin
          mon_b = rb_q.pop_front();
          check("rd_data", 32'(rd_data), 32'(mon_b.data));
          check("rd_last", 32'(rd_last), 32'(mon_b.last));
        end
      end
      if (done) begin
        check("done_expected", 32'(done_q.size() > 0), 1);
        if (done_q.size() > 0) check("done_err", 32'(err), 32'(done_q.pop_front()));
      end
    end
  end

  function automatic vec_t mk(input logic w, input logic [7:0] a, input logic [1:0] l,
                              input logic [7:0] d0, input logic [7:0] d1,
                              input logic [7:0] d2, input logic [7:0] d3, input logic e);
    vec_t v;
    v.w = w; v.a = a; v.l = l; v.d = {d3, d2, d1, d0}; v.e = e;
    return v;
  endfunction

  task automatic push_exp(input vec_t v);
    logic [7:0] ad;
    if (v.e) begin
      done_q.push_back(1'b1);
    end else begin
      for (int i = 0; i <= int'(v.l); i++) begin
        ad = 8'((int'(v.a) + i) % 8);
        if (v.w) ws_q.push_back({ad, v.d[i]});
        else begin
          rs_q.push_back(ad);
          rb_q.push_back({v.d[i], i == int'(v.l)});
        end
      end
      done_q.push_back(1'b0);
    end
  endtask

  task automatic send_cmd(input logic w, input logic [7:0] a, input logic [1:0] l);
    int n;
    n = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_len = l;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    check("req_ready_seen", 32'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 80) begin @(negedge clk); n++; end
    check("done_seen", 32'(done), 1);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 0);
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    push_exp(v);
    send_cmd(v.w, v.a, v.l);
    if (v.w && !v.e) begin
      for (int i = 0; i <= int'(v.l); i++) begin
        wr_valid = 1'b1; wr_data = v.d[i];
        n = 0;
        @(negedge clk);
        while (!wr_ready && n < 50) begin @(negedge clk); n++; end
        check("wr_ready_seen", 32'(wr_ready), 1);
        @(posedge clk); #1;
      end
      wr_valid = 1'b0;
    end
    wait_done();
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_mem_cs"}, 32'(mem_cs), 0);
    check({tag, "_mem_rd"}, 32'(mem_rd), 1);
    check({tag, "_mem_addr"}, 32'(mem_addr), 0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 0);
    check({tag, "_rd_data"}, 32'(rd_data), 0);
    check({tag, "_rd_last"}, 32'(rd_last), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_wr_ready"}, 32'(wr_ready), 0);
    check({tag, "_req_ready"}, 32'(req_ready), 1);
  endtask

  vec_t vt[11];
  logic [7:0] held;
  int n;

  initial begin
    vt[0]  = mk(1, 8'd3,   2'd0, 8'hA5, 8'h00, 8'h00, 8'h00, 0);
    vt[1]  = mk(0, 8'd3,   2'd0, 8'hA5, 8'h00, 8'h00, 8'h00, 0);
    vt[2]  = mk(1, 8'd6,   2'd3, 8'h11, 8'h22, 8'h33, 8'h44, 0);
    vt[3]  = mk(0, 8'd6,   2'd3, 8'h11, 8'h22, 8'h33, 8'h44, 0);
    vt[4]  = mk(1, 8'd8,   2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1);
    vt[5]  = mk(0, 8'd8,   2'd1, 8'h00, 8'h00, 8'h00, 8'h00, 1);
    vt[6]  = mk(1, 8'd7,   2'd1, 8'h5A, 8'hC3, 8'h00, 8'h00, 0);
    vt[7]  = mk(0, 8'd0,   2'd1, 8'hC3, 8'h44, 8'h00, 8'h00, 0);
    vt[8]  = mk(0, 8'd7,   2'd0, 8'h5A, 8'h00, 8'h00, 8'h00, 0);
    vt[9]  = mk(0, 8'd5,   2'd2, 8'hF5, 8'h11, 8'h5A, 8'h00, 0);
    vt[10] = mk(1, 8'hFF,  2'd2, 8'h00, 8'h00, 8'h00, 8'h00, 1);

    #12;
    check_reset_outs("rst");
    @(posedge clk); #1 resetn = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(vt[i]);

    // Read latency: command edge E0, rd_valid first seen after E0+2.
    push_exp(mk(0, 8'd3, 2'd0, 8'hA5, 8'h00, 8'h00, 8'h00, 0));
    send_cmd(1'b0, 8'd3, 2'd0);
    n = 0;
    do begin @(negedge clk); n++; end while (!rd_valid && n < 20);
    check("rd_latency", 32'(n), 3);
    check("lat_rd_data", 32'(rd_data), 32'hA5);
    check("lat_rd_last", 32'(rd_last), 1);
    wait_done();

    // Out-of-range write: single done/err cycle, then req_ready returns.
    push_exp(mk(1, 8'd8, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1));
    send_cmd(1'b1, 8'd8, 2'd0);
    @(negedge clk);
    check("oor_done", 32'(done), 1);
    check("oor_err", 32'(err), 1);
    check("oor_req_ready_busy", 32'(req_ready), 0);
    @(negedge clk);
    check("oor_done_drop", 32'(done), 0);
    check("oor_req_ready_back", 32'(req_ready), 1);
    @(posedge clk); #1;

    // Read burst with beat 2 stalled for 5 cycles.
    rd_ready = 1'b0;
    push_exp(mk(0, 8'd6, 2'd3, 8'h11, 8'h5A, 8'hC3, 8'h44, 0));
    send_cmd(1'b0, 8'd6, 2'd3);
    for (int b = 0; b < 4; b++) begin
      n = 0;
      @(negedge clk);
      while (!rd_valid && n < 20) begin @(negedge clk); n++; end
      check("stall_beat_valid", 32'(rd_valid), 1);
      held = rd_data;
      if (b == 1) begin
        repeat (5) begin
          @(negedge clk);
          check("stall_valid_held", 32'(rd_valid), 1);
          check("stall_data_held", 32'(rd_data), 32'(held));
          check("stall_mem_cs_low", 32'(mem_cs), 0);
        end
      end
      @(posedge clk); #1 rd_ready = 1'b1;
      @(posedge clk); #1 rd_ready = 1'b0;
    end
    wait_done();
    rd_ready = 1'b1;

    // Gapped write beats (1 on, 2 off), len=1 at addr 4.
    push_exp(mk(1, 8'd4, 2'd1, 8'h77, 8'h88, 8'h00, 8'h00, 0));
    send_cmd(1'b1, 8'd4, 2'd1);
    for (int b = 0; b < 2; b++) begin
      wr_valid = 1'b1; wr_data = (b == 0) ? 8'h77 : 8'h88;
      @(negedge clk);
      check("gap_wr_ready", 32'(wr_ready), 1);
      @(posedge clk); #1 wr_valid = 1'b0;
      @(negedge clk);
      check("gap_strobe_cs", 32'(mem_cs), 1);
      check("gap_strobe_addr", 32'(mem_addr), 32'(4 + b));
      if (b == 1) check("gap_done", 32'(done), 1);
      @(negedge clk);
      check("gap_cs_idle", 32'(mem_cs), 0);
      @(posedge clk); #1;
    end
    run_vec(mk(0, 8'd4, 2'd1, 8'h77, 8'h88, 8'h00, 8'h00, 0));

    // Reset during the 2nd beat of a 4-beat write at addr 2.
    ws_q.push_back({8'd2, 8'h61});
    send_cmd(1'b1, 8'd2, 2'd3);
    wr_valid = 1'b1; wr_data = 8'h61;
    @(posedge clk); #1 wr_data = 8'h62;
    @(posedge clk); #1 resetn = 1'b0; wr_valid = 1'b0;
    #1 check("arst_mem_cs", 32'(mem_cs), 0);
    repeat (2) begin
      @(negedge clk);
      check_reset_outs("arst");
    end
    @(posedge clk); #1 resetn = 1'b1;
    run_vec(mk(0, 8'd2, 2'd0, 8'h61, 8'h00, 8'h00, 8'h00, 0));
    run_vec(mk(0, 8'd3, 2'd0, 8'hA5, 8'h00, 8'h00, 8'h00, 0));

    repeat (3) @(negedge clk);
    check("ws_q_empty", 32'(ws_q.size()), 0);
    check("rs_q_empty", 32'(rs_q.size()), 0);
    check("rb_q_empty", 32'(rb_q.size()), 0);
    check("done_q_empty", 32'(done_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
